// File: rtl/pipearch_arb_pkg.sv
// Shared types, constants and the round-robin pick function for the BRAM read arbiter.
package pipearch_arb_pkg;

    typedef logic [2:0] t_reqid;

    localparam logic [1:0] FIFOBRAM_MODE_BRAM = 2'b01;

    // Widest requester vector the pick function handles; callers zero-extend.
    localparam int MAX_REQ = 8;

    // One-hot grant for the first valid requester after 'last', wrapping at num_req.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0] valid,
        input t_reqid             last,
        input int                 num_req
    );
        logic [MAX_REQ-1:0] grant;
        logic               found;
        t_reqid             idx;
        grant = '0;
        found = 1'b0;
        idx   = last;
        for (int i = 1; i <= MAX_REQ; i++) begin
            if (i <= num_req) begin
                idx = (idx == t_reqid'(num_req - 1)) ? 3'd0 : idx + 3'd1;
                if (valid[idx] && !found) begin
                    grant[idx] = 1'b1;
                    found      = 1'b1;
                end
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fifobram_interface.sv
// Read side of a FIFO/BRAM region port.
interface fifobram_interface #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 512
);
    logic                  re;
    logic [ADDR_WIDTH-1:0] raddr;
    logic [1:0]            rfifobram;
    logic                  rvalid;
    logic [DATA_WIDTH-1:0] rdata;

    modport read (
        output re,
        output raddr,
        output rfifobram,
        input  rvalid,
        input  rdata
    );
endinterface

// File: rtl/pipearch_tag_fifo.sv
// In-order tag FIFO: remembers which requester owns each in-flight read.
module pipearch_tag_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign empty    = (count == '0);
    assign full     = (count == (PTR_W+1)'(DEPTH));
    assign pop_data = mem[rd_ptr];

    // Storage array, no reset needed since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pipearch_bram_read_arbiter.sv
// Round-robin arbiter sharing one BRAM read port among NUM_REQ requesters,
// routing each returned line back to its issuer through an in-order tag FIFO.
module pipearch_bram_read_arbiter
    import pipearch_arb_pkg::*;
#(
    parameter int NUM_REQ         = 4,
    parameter int ADDR_WIDTH      = 16,
    parameter int DATA_WIDTH      = 512,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]  req_addr,
    output logic [NUM_REQ-1:0]                  req_grant,
    output logic [NUM_REQ-1:0]                  resp_valid,
    output logic [DATA_WIDTH-1:0]               resp_data,
    output logic                                err_unexpected,
    fifobram_interface.read                     REGION_read
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0]      last;
    logic [CNT_W-1:0]      outstanding;
    logic [MAX_REQ-1:0]    pick;
    logic                  can_issue;
    logic                  accept;
    logic [IDX_W-1:0]      accept_idx;
    logic                  pop;
    logic [IDX_W-1:0]      tag_out;
    logic                  tag_empty;
    logic                  tag_full;
    logic                  re_q;
    logic [ADDR_WIDTH-1:0] raddr_q;

    // Grant the next valid requester after 'last' while there is room in flight.
    always_comb begin
        pick      = rr_pick(MAX_REQ'(req_valid), t_reqid'(last), NUM_REQ);
        can_issue = (outstanding < CNT_MAX) && !tag_full;
        req_grant = can_issue ? pick[NUM_REQ-1:0] : '0;
    end

    // Encode the one-hot grant into the requester index that gets tagged.
    always_comb begin
        accept_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (req_grant[k]) accept_idx = IDX_W'(k);
        end
    end

    assign accept = |(req_valid & req_grant);
    // A return with no tag is an orphan: it is dropped and flagged, not counted.
    assign pop    = REGION_read.rvalid && !tag_empty;

    pipearch_tag_fifo #(
        .WIDTH (IDX_W),
        .DEPTH (MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept),
        .push_data (accept_idx),
        .pop       (pop),
        .pop_data  (tag_out),
        .empty     (tag_empty),
        .full      (tag_full)
    );

    // Round-robin pointer and in-flight counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last        <= IDX_W'(NUM_REQ - 1);
            outstanding <= '0;
        end else begin
            if (accept) last <= accept_idx;
            case ({accept, pop})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

    // Issue register toward the BRAM; raddr holds its last value between reads.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            re_q    <= 1'b0;
            raddr_q <= '0;
        end else begin
            re_q <= accept;
            if (accept) raddr_q <= req_addr[accept_idx];
        end
    end

    // Response routing: pulse the owner of the popped tag and capture the line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            resp_valid     <= '0;
            resp_data      <= '0;
            err_unexpected <= 1'b0;
        end else begin
            resp_valid <= '0;
            if (pop) begin
                resp_valid[tag_out] <= 1'b1;
                resp_data           <= REGION_read.rdata;
            end
            if (REGION_read.rvalid && tag_empty) err_unexpected <= 1'b1;
        end
    end

    assign REGION_read.re        = re_q;
    assign REGION_read.raddr     = raddr_q;
    assign REGION_read.rfifobram = FIFOBRAM_MODE_BRAM;

endmodule

// File: tb/tb_pipearch_bram_read_arbiter.sv
// Directed bench for the BRAM read arbiter with a fixed-latency BRAM model.
module tb_pipearch_bram_read_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 512;
    localparam int MAX_OUTSTANDING = 8;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic [NUM_REQ-1:0] req_valid = '0;
    logic [NUM_REQ-1:0][ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ-1:0] req_grant;
    logic [NUM_REQ-1:0] resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic err_unexpected;

    int n_cmp = 0;
    int n_bad = 0;

    fifobram_interface #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) bus ();

    pipearch_bram_read_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
        .req_grant(req_grant), .resp_valid(resp_valid), .resp_data(resp_data),
        .err_unexpected(err_unexpected), .REGION_read(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] data_of(input logic [15:0] a);
        return {16{{a ^ 16'h5A5A, a}}};
    endfunction

    // BRAM model: a read seen in cycle x returns in cycle x+lat; 'inject' forces a stray return.
    int cyc = 0;
    int lat = 2;
    logic inject = 1'b0;
    logic slot_v [64];
    logic [15:0] slot_a [64];
    localparam logic [DATA_WIDTH-1:0] INJ_DATA = {16{32'hDEADBEEF}};

    initial begin
        for (int i = 0; i < 64; i++) begin
            slot_v[i] = 1'b0;
            slot_a[i] = '0;
        end
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        int k;
        k = cyc % 64;
        bus.rvalid = slot_v[k] | inject;
        bus.rdata  = slot_v[k] ? data_of(slot_a[k]) : (inject ? INJ_DATA : '0);
        slot_v[k] = 1'b0;
        if (bus.re === 1'b1) begin
            slot_v[(cyc + lat) % 64] = 1'b1;
            slot_a[(cyc + lat) % 64] = bus.raddr;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        req_valid = '0;
        repeat (n) step();
    endtask

    task automatic reset_dut();
        req_valid = '0;
        inject = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (bus.re !== 1'b0) begin n_bad++; $display("FAIL reset_re got=%b want=0", bus.re); end
        n_cmp++; if (bus.raddr !== 16'h0) begin n_bad++; $display("FAIL reset_raddr got=%h want=0000", bus.raddr); end
        n_cmp++; if (bus.rfifobram !== 2'b01) begin n_bad++; $display("FAIL reset_rfifobram got=%b want=01", bus.rfifobram); end
        n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL reset_resp_valid got=%b want=0000", resp_valid); end
        n_cmp++; if (resp_data !== '0) begin n_bad++; $display("FAIL reset_resp_data got=%h want=0", resp_data); end
        n_cmp++; if (err_unexpected !== 1'b0) begin n_bad++; $display("FAIL reset_err got=%b want=0", err_unexpected); end
        n_cmp++; if (req_grant !== 4'b0000) begin n_bad++; $display("FAIL reset_grant_idle got=%b want=0000", req_grant); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        step();
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_grant !== 4'b0001) begin n_bad++; $display("FAIL reset_first_priority got=%b want=0001", req_grant); end
        req_valid = 4'b0000;
    endtask

    task automatic test_single();
        lat = 2;
        req_addr[2] = 16'h0010;
        for (int i = 0; i < 6; i++) begin
            step();
            req_valid = (i == 0) ? 4'b0100 : 4'b0000;
            #1;
            if (i == 0) begin
                n_cmp++; if (req_grant !== 4'b0100) begin n_bad++; $display("FAIL single_grant got=%b want=0100", req_grant); end
            end
            n_cmp++; if (bus.re !== (i == 1)) begin n_bad++; $display("FAIL single_re i=%0d got=%b want=%b", i, bus.re, (i == 1)); end
            if (i == 1) begin
                n_cmp++; if (bus.raddr !== 16'h0010) begin n_bad++; $display("FAIL single_raddr got=%h want=0010", bus.raddr); end
            end
            n_cmp++; if (resp_valid !== ((i == 4) ? 4'b0100 : 4'b0000)) begin n_bad++; $display("FAIL single_resp_valid i=%0d got=%b", i, resp_valid); end
            if (i >= 4) begin
                n_cmp++; if (resp_data !== data_of(16'h0010)) begin n_bad++; $display("FAIL single_resp_data i=%0d got=%h", i, resp_data); end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        logic [3:0] exp_r;
        reset_dut();
        lat = 3;
        for (int k = 0; k < NUM_REQ; k++) req_addr[k] = 16'h0100 + 16'(k);
        for (int i = 0; i < 14; i++) begin
            step();
            req_valid = (i < 8) ? 4'b1111 : 4'b0000;
            #1;
            exp_g = (i < 8) ? 4'(1 << (i % 4)) : 4'b0000;
            exp_r = (i >= 5 && i <= 12) ? 4'(1 << ((i - 5) % 4)) : 4'b0000;
            n_cmp++; if (req_grant !== exp_g) begin n_bad++; $display("FAIL rr_grant i=%0d got=%b want=%b", i, req_grant, exp_g); end
            n_cmp++; if (bus.re !== (i >= 1 && i <= 8)) begin n_bad++; $display("FAIL rr_re i=%0d got=%b", i, bus.re); end
            if (i >= 1 && i <= 8) begin
                n_cmp++; if (bus.raddr !== 16'h0100 + 16'((i - 1) % 4)) begin n_bad++; $display("FAIL rr_raddr i=%0d got=%h", i, bus.raddr); end
            end
            n_cmp++; if (resp_valid !== exp_r) begin n_bad++; $display("FAIL rr_resp_valid i=%0d got=%b want=%b", i, resp_valid, exp_r); end
            if (exp_r != 4'b0000) begin
                n_cmp++; if (resp_data !== data_of(16'h0100 + 16'((i - 5) % 4))) begin n_bad++; $display("FAIL rr_resp_data i=%0d got=%h", i, resp_data); end
            end
        end
    endtask

    task automatic test_outstanding_limit();
        logic [3:0] exp_g;
        int n_acc;
        n_acc = 0;
        reset_dut();
        lat = 12;
        for (int k = 0; k < NUM_REQ; k++) req_addr[k] = 16'h0200 + 16'(k);
        for (int i = 0; i < 24; i++) begin
            step();
            req_valid = 4'b1111;
            #1;
            if (i < 8) exp_g = 4'(1 << (i % 4));
            else if (i >= 14 && i <= 21) exp_g = 4'(1 << ((i - 14) % 4));
            else exp_g = 4'b0000;
            n_cmp++; if (req_grant !== exp_g) begin n_bad++; $display("FAIL limit_grant i=%0d got=%b want=%b", i, req_grant, exp_g); end
            if (i < 14 && (req_valid & req_grant) != 4'b0000) n_acc++;
        end
        n_cmp++; if (n_acc !== 8) begin n_bad++; $display("FAIL limit_accepts got=%0d want=8", n_acc); end
        drain(20);
    endtask

    task automatic test_same_cycle();
        logic [3:0] rv_tab [11];
        logic [3:0] exp_r;
        reset_dut();
        lat = 3;
        for (int k = 0; k < NUM_REQ; k++) req_addr[k] = 16'h0300 + 16'(k);
        for (int i = 0; i < 11; i++) rv_tab[i] = 4'b0000;
        rv_tab[0] = 4'b0010;
        rv_tab[1] = 4'b0100;
        rv_tab[2] = 4'b1000;
        rv_tab[4] = 4'b0001;
        for (int i = 0; i < 11; i++) begin
            step();
            req_valid = rv_tab[i];
            #1;
            n_cmp++; if (req_grant !== rv_tab[i]) begin n_bad++; $display("FAIL same_grant i=%0d got=%b want=%b", i, req_grant, rv_tab[i]); end
            if (i == 4 || i == 5) begin
                n_cmp++; if (dut.outstanding !== 4'd3) begin n_bad++; $display("FAIL same_outstanding i=%0d got=%0d want=3", i, dut.outstanding); end
            end
            if (i == 6) begin
                n_cmp++; if (dut.outstanding !== 4'd2) begin n_bad++; $display("FAIL same_outstanding_after i=%0d got=%0d want=2", i, dut.outstanding); end
            end
            case (i)
                5: exp_r = 4'b0010;
                6: exp_r = 4'b0100;
                7: exp_r = 4'b1000;
                9: exp_r = 4'b0001;
                default: exp_r = 4'b0000;
            endcase
            n_cmp++; if (resp_valid !== exp_r) begin n_bad++; $display("FAIL same_resp_valid i=%0d got=%b want=%b", i, resp_valid, exp_r); end
            if (i == 5) begin
                n_cmp++; if (resp_data !== data_of(16'h0301)) begin n_bad++; $display("FAIL same_resp_data5 got=%h", resp_data); end
            end
            if (i == 9) begin
                n_cmp++; if (resp_data !== data_of(16'h0300)) begin n_bad++; $display("FAIL same_resp_data9 got=%h", resp_data); end
            end
        end
    endtask

    task automatic test_unexpected();
        for (int i = 0; i < 4; i++) begin
            step();
            inject = (i == 0);
            #1;
            if (i == 0) begin
                n_cmp++; if (err_unexpected !== 1'b0) begin n_bad++; $display("FAIL unexp_err_before got=%b want=0", err_unexpected); end
            end
            if (i == 1) begin
                n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL unexp_resp_valid got=%b want=0000", resp_valid); end
                n_cmp++; if (err_unexpected !== 1'b1) begin n_bad++; $display("FAIL unexp_err got=%b want=1", err_unexpected); end
                n_cmp++; if (dut.outstanding !== 4'd0) begin n_bad++; $display("FAIL unexp_outstanding got=%0d want=0", dut.outstanding); end
                n_cmp++; if (resp_data !== data_of(16'h0300)) begin n_bad++; $display("FAIL unexp_resp_data_held got=%h", resp_data); end
            end
            if (i == 3) begin
                n_cmp++; if (err_unexpected !== 1'b1) begin n_bad++; $display("FAIL unexp_err_sticky got=%b want=1", err_unexpected); end
            end
        end
    endtask

    task automatic test_reset_midflight();
        reset_dut();
        n_cmp++; if (err_unexpected !== 1'b0) begin n_bad++; $display("FAIL mid_err_cleared got=%b want=0", err_unexpected); end
        lat = 10;
        for (int k = 0; k < NUM_REQ; k++) req_addr[k] = 16'h0400 + 16'(k);
        for (int i = 0; i < 5; i++) begin
            step();
            req_valid = 4'b1111;
            #1;
            n_cmp++; if (req_grant !== 4'(1 << (i % 4))) begin n_bad++; $display("FAIL mid_grant i=%0d got=%b", i, req_grant); end
        end
        step();
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (bus.re !== 1'b1) begin n_bad++; $display("FAIL mid_re_before got=%b want=1", bus.re); end
        n_cmp++; if (bus.raddr !== 16'h0400) begin n_bad++; $display("FAIL mid_raddr_before got=%h want=0400", bus.raddr); end
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.re !== 1'b0) begin n_bad++; $display("FAIL mid_re_async got=%b want=0", bus.re); end
        n_cmp++; if (bus.raddr !== 16'h0000) begin n_bad++; $display("FAIL mid_raddr_async got=%h want=0000", bus.raddr); end
        n_cmp++; if (dut.outstanding !== 4'd0) begin n_bad++; $display("FAIL mid_outstanding_async got=%0d want=0", dut.outstanding); end
        n_cmp++; if (dut.u_tag_fifo.empty !== 1'b1) begin n_bad++; $display("FAIL mid_fifo_empty got=%b want=1", dut.u_tag_fifo.empty); end
        step();
        reset = 1'b1;
        for (int i = 7; i < 19; i++) begin
            step();
            #1;
            n_cmp++; if (resp_valid !== 4'b0000) begin n_bad++; $display("FAIL mid_resp_valid i=%0d got=%b want=0000", i, resp_valid); end
            if (i == 10) begin
                n_cmp++; if (err_unexpected !== 1'b0) begin n_bad++; $display("FAIL mid_err_early got=%b want=0", err_unexpected); end
            end
            if (i == 18) begin
                n_cmp++; if (err_unexpected !== 1'b1) begin n_bad++; $display("FAIL mid_err_late got=%b want=1", err_unexpected); end
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_outstanding_limit();
        test_same_cycle();
        test_unexpected();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pipearch_bram_read_arbiter.md
# pipearch_bram_read_arbiter

Shares one `fifobram_interface.read` port among `NUM_REQ` requesters, such as several load-register units or a load-register unit plus a streaming consumer. It uses round-robin arbitration, one issue per cycle, and up to `MAX_OUTSTANDING` reads in flight. Each returned line is routed back to the requester that issued it, using an in-order tag FIFO. The block sits between the instruction-level units and a single BRAM region.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `ADDR_WIDTH`, 16: region line address width.
- `DATA_WIDTH`, 512: line width (16 × 32-bit words).
- `MAX_OUTSTANDING`, 8: maximum in-flight reads; power of two, ≥2.

Ports:
- `clk` in 1: clock; all logic on the rising edge.
- `reset` in 1: reset, asynchronous and active-low (0 = reset asserted).
- `req_valid` in `[NUM_REQ]`: requester k requests a read.
- `req_addr` in `[NUM_REQ][ADDR_WIDTH]`: line address; held stable while `req_valid` is high.
- `req_grant` out `[NUM_REQ]`: combinational. At most one bit set. `req_valid[k] & req_grant[k]` means the request is accepted this cycle.
- `resp_valid` out `[NUM_REQ]`: registered. One-cycle pulse to the owner of the returned line.
- `resp_data` out `DATA_WIDTH`: registered. Returned line, shared by all requesters; qualified by `resp_valid`.
- `err_unexpected` out 1: sticky. Set when `rvalid` arrives while the tag FIFO is empty.
- `REGION_read` `fifobram_interface.read`: drives `re`, `raddr`, `rfifobram`; samples `rvalid`, `rdata`.

## Operation
- Round-robin arbitration:
  - Pointer `last` (`$clog2(NUM_REQ)` bits) holds the index of the last accepted requester.
  - The search order is `last+1`, `last+2`, … (modulo `NUM_REQ`).
  - The first requester in that order with `req_valid` set receives the grant.
- Grants are issued only when `outstanding < MAX_OUTSTANDING`. Otherwise all grants are 0.
- On accept of requester k:
  - Push k into the tag FIFO.
  - Set `last` to k.
  - Register `re` = 1 and `raddr` = `req_addr[k]`.
- `re` defaults to 0 each cycle. `rfifobram` is driven constantly as 2'b01 (BRAM mode).
- `outstanding` counter (`$clog2(MAX_OUTSTANDING)+1` bits):
  - +1 on accept, −1 on `rvalid`.
  - Both in the same cycle: no change.
  - Never exceeds `MAX_OUTSTANDING` and never goes below 0.
- On `rvalid` with the tag FIFO non-empty:
  - Pop tag t.
  - Next cycle: `resp_valid[t]` = 1 and `resp_data` = `rdata`.
- On `rvalid` with the tag FIFO empty:
  - Drop the data; no `resp_valid`.
  - Set `err_unexpected` = 1.
  - `outstanding` stays at 0.
- Responses return in issue order. The BRAM latency may be any fixed value ≥1; the block does not depend on it.
- `resp_data` holds its last value while `resp_valid` is all zeros.

## Timing
- Reset values:
  - `re` = 0, `raddr` = 0, `rfifobram` = 2'b01.
  - `resp_valid` = all 0, `resp_data` = 0, `err_unexpected` = 0.
  - `last` = `NUM_REQ-1`, so requester 0 has first priority after reset.
  - `outstanding` = 0; tag FIFO empty.
- Issue latency: accept in cycle c → `re`/`raddr` visible in cycle c+1.
- Return latency: `rvalid` in cycle r → `resp_valid`/`resp_data` visible in cycle r+1.
- Throughput: one accept per cycle when requests are continuous and the block is not at the outstanding limit.
- Full boundary: when `outstanding == MAX_OUTSTANDING`, grants are 0. A return in that cycle does not enable a same-cycle grant; the grant happens the following cycle.
- Reset mid-operation:
  - The tag FIFO and counters clear immediately.
  - In-flight BRAM returns after reset release are dropped and set `err_unexpected`.
- Requesters may drop `req_valid` before being granted; no state changes.

## Structure
- Package `pipearch_arb_pkg` holds:
  - `t_reqid` (`logic [2:0]`);
  - the constant `FIFOBRAM_MODE_BRAM` = 2'b01;
  - the function `rr_pick(valid, last)` returning a grant one-hot.
- Sub-module `pipearch_tag_fifo`: synchronous FIFO with depth `MAX_OUTSTANDING` and width `$clog2(NUM_REQ)`.
  - Push and pop in the same cycle are legal.
  - Provides `empty` and `full` outputs.
  - Reset is asynchronous and active-low.
- The arbiter top holds the round-robin pointer, the counter, and the output registers.

## Test plan
- Single request: requester 2 with `raddr` 0x0010 and BRAM latency 2.
  - Expect `re` in cycle c+1.
  - Expect `resp_valid[2]` in c+4 with the `rdata` the BRAM returned.
- All four requesters asserted continuously with MAX_OUTSTANDING = 8.
  - Expect grants in the order 0,1,2,3,0,1,…
  - Expect one `re` per cycle.
  - Expect responses routed to their owners in the same order.
- Outstanding limit: BRAM latency 12 and constant requests.
  - Expect exactly 8 accepts, then grants held at 0 until the first `rvalid`.
  - After that, one accept per return.
- Same-cycle accept and `rvalid` at `outstanding` = 3.
  - Expect the count to stay at 3.
  - Expect the tag FIFO to both push and pop, with the correct owner.
- `rvalid` injected with no outstanding reads.
  - Expect no `resp_valid` and `err_unexpected` = 1, held until reset.
- Reset asserted with 5 reads in flight.
  - Outputs go to reset values without waiting for `clk`.
  - Late returns are dropped and set `err_unexpected`.
